// File: rtl/temp_poll_seq.sv
// temp_poll_seq: polls an I2C temperature sensor through an external I2C master.
// The sensor gets one config write when enabled, then a register read every POLL_DIV+1
// cycles. Failed transactions are retried up to MAX_RETRY times. A timeout, or running
// out of retries, parks the block in a sticky FAULT state until enable is dropped.
module temp_poll_seq #(
  parameter int         POLL_DIV  = 1000,
  parameter int         TIMEOUT   = 4095,
  parameter int         MAX_RETRY = 3,
  parameter logic [7:0] CFG_DATA  = 8'h20
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       enable,
  input  logic [2:0] dev_adr,
  input  logic       i2c_end,
  input  logic [7:0] temp_input,
  input  logic [3:0] temp_error,
  output logic       start,
  output logic       rw,
  output logic [2:0] adr,
  output logic [7:0] temp_reg_d1,
  output logic [7:0] temp_output_d2,
  output logic [7:0] temp_value,
  output logic       temp_valid,
  output logic       busy,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV + 1) : 1;

  // The wait counter holds (wait cycles so far - 1), so this value marks the last
  // permitted wait cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  // The period counter runs POLL_LOAD..0, giving POLL_DIV cycles in PERIOD.
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_DIV - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

  // Sensor register pointers and the read-side data byte.
  localparam logic [7:0] REG_TEMP   = 8'h00;
  localparam logic [7:0] REG_CONFIG = 8'h01;
  localparam logic [7:0] DATA_NONE  = 8'h00;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_GO   = 3'd1,
    CFG_WAIT = 3'd2,
    PERIOD   = 3'd3,
    RD_GO    = 3'd4,
    RD_WAIT  = 3'd5,
    FAULT    = 3'd6
  } state_t;

  state_t            state_r;
  logic [3:0]        err_snap_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [POLL_W-1:0] poll_cnt_r;

  logic end_good_s;
  logic timeout_s;
  logic can_retry_s;
  logic in_read_s;

  // The address is a plain pass-through of the device strap bits.
  assign adr = dev_adr;

  // A transaction is good when the master's error counter did not move while it ran.
  assign end_good_s  = (temp_error == err_snap_r);
  assign timeout_s   = (wait_cnt_r >= WAIT_LAST);
  assign can_retry_s = (retry_cnt < RETRY_MAX);
  assign in_read_s   = (state_r == RD_WAIT);

  // Polling FSM together with all registered outputs and counters.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r        <= IDLE;
      err_snap_r     <= 4'd0;
      wait_cnt_r     <= '0;
      poll_cnt_r     <= '0;
      start          <= 1'b0;
      rw             <= 1'b0;
      temp_reg_d1    <= 8'h00;
      temp_output_d2 <= 8'h00;
      temp_value     <= 8'h00;
      temp_valid     <= 1'b0;
      busy           <= 1'b0;
      fault          <= 1'b0;
      retry_cnt      <= 2'd0;
    end else begin
      // start and temp_valid are single-cycle pulses; they only rise on the
      // transitions that explicitly request them below.
      start      <= 1'b0;
      temp_valid <= 1'b0;

      case (state_r)
        IDLE: begin
          // A stray i2c_end here is simply ignored.
          if (enable) begin
            state_r        <= CFG_GO;
            busy           <= 1'b1;
            start          <= 1'b1;
            rw             <= 1'b0;
            temp_reg_d1    <= REG_CONFIG;
            temp_output_d2 <= CFG_DATA;
          end
        end

        CFG_GO: begin
          // start is high during this cycle; snapshot the error counter so
          // that only errors raised by this transaction are counted.
          err_snap_r <= temp_error;
          wait_cnt_r <= '0;
          state_r    <= CFG_WAIT;
        end

        RD_GO: begin
          err_snap_r <= temp_error;
          wait_cnt_r <= '0;
          state_r    <= RD_WAIT;
        end

        CFG_WAIT, RD_WAIT: begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          // i2c_end wins over a timeout that falls in the same cycle.
          if (i2c_end) begin
            if (end_good_s) begin
              retry_cnt  <= 2'd0;
              poll_cnt_r <= POLL_LOAD;
              state_r    <= PERIOD;
              if (in_read_s) begin
                temp_value <= temp_input;
                temp_valid <= 1'b1;
              end
            end else if (can_retry_s) begin
              // rw / register / data still hold the values loaded on entry
              // to this GO state, so a retry only has to reissue start.
              retry_cnt <= retry_cnt + 2'd1;
              start     <= 1'b1;
              state_r   <= in_read_s ? RD_GO : CFG_GO;
            end else begin
              fault   <= 1'b1;
              busy    <= 1'b0;
              state_r <= FAULT;
            end
          end else if (timeout_s) begin
            // A master that never answers is not worth retrying.
            fault   <= 1'b1;
            busy    <= 1'b0;
            state_r <= FAULT;
          end
        end

        PERIOD: begin
          // enable is only honoured between transactions, never mid-transfer.
          if (!enable) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 2'd0;
          end else if (poll_cnt_r == '0) begin
            state_r        <= RD_GO;
            start          <= 1'b1;
            rw             <= 1'b1;
            temp_reg_d1    <= REG_TEMP;
            temp_output_d2 <= DATA_NONE;
          end else begin
            poll_cnt_r <= poll_cnt_r - POLL_W'(1);
          end
        end

        FAULT: begin
          // Sticky until the host withdraws enable.
          if (!enable) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          start   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_poll_seq.sv
// tb_temp_poll_seq: scenario tasks drive a simple I2C-master stand-in and compare
// the sequencer's outputs against expectations derived from the polling rules.
module tb_temp_poll_seq;

  localparam int         POLL_DIV  = 20;
  localparam int         TIMEOUT   = 50;
  localparam int         MAX_RETRY = 2;
  localparam logic [7:0] CFG_DATA  = 8'h20;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] dev_adr = 3'd0;
  logic       i2c_end = 1'b0;
  logic [7:0] temp_input = 8'h00;
  logic [3:0] temp_error = 4'd0;
  logic       start, rw, temp_valid, busy, fault;
  logic [2:0] adr;
  logic [7:0] temp_reg_d1, temp_output_d2, temp_value;
  logic [1:0] retry_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state: the last reading the sequencer should have accepted.
  logic [7:0] exp_value = 8'h00;

  logic start_prev = 1'b0;
  logic b2b_seen = 1'b0;

  temp_poll_seq #(
    .POLL_DIV (POLL_DIV),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .CFG_DATA (CFG_DATA)
  ) dut (
    .CLK           (CLK),
    .RES           (RES),
    .enable        (enable),
    .dev_adr       (dev_adr),
    .i2c_end       (i2c_end),
    .temp_input    (temp_input),
    .temp_error    (temp_error),
    .start         (start),
    .rw            (rw),
    .adr           (adr),
    .temp_reg_d1   (temp_reg_d1),
    .temp_output_d2(temp_output_d2),
    .temp_value    (temp_value),
    .temp_valid    (temp_valid),
    .busy          (busy),
    .fault         (fault),
    .retry_cnt     (retry_cnt)
  );

  always #5 CLK = ~CLK;

  // Watch for start asserted in two consecutive cycles.
  always @(posedge CLK) begin
    if (start === 1'b1 && start_prev === 1'b1) b2b_seen <= 1'b1;
    start_prev <= start;
  end

  // Retry counter expected after attempt number 'attempt' (0-based) of one transaction.
  function automatic logic [1:0] exp_retry(input int attempt, input bit failed);
    if (!failed) return 2'd0;
    if (attempt < MAX_RETRY) return 2'(attempt + 1);
    return 2'(MAX_RETRY);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Tick until start is seen, or until 'limit' ticks have gone by.
  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (start !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  // Master stand-in: called in the GO cycle; ends the transfer 'lat' cycles after
  // start. A failing transfer bumps the error counter after the sequencer's snapshot.
  task automatic run_attempt(input int lat, input logic [7:0] data, input bit failed);
    tick();
    if (failed) temp_error = temp_error + 4'd1;
    repeat (lat - 1) tick();
    i2c_end = 1'b1;
    temp_input = data;
    tick();
    i2c_end = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    RES = 1'b1;
    dev_adr = 3'($urandom);
    repeat (3) tick();
    total++; if ({start, rw, temp_reg_d1, temp_output_d2, temp_value, temp_valid, busy, fault, retry_cnt} !== 31'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {start, rw, temp_reg_d1, temp_output_d2, temp_value, temp_valid, busy, fault, retry_cnt}); end
    total++; if (adr !== dev_adr) begin bad++; $display("FAIL adr_passthru: got %0d want %0d", adr, dev_adr); end
    RES = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start === 1'b1) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL idle_no_start: got %0d starts want 0", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_startup();
    int n;
    temp_error = 4'($urandom);
    enable = 1'b1;
    wait_start(5, n);
    total++; if (n !== 1) begin bad++; $display("FAIL cfg_start_latency: got %0d want 1", n); end
    total++; if ({rw, temp_reg_d1, temp_output_d2} !== {1'b0, 8'h01, CFG_DATA}) begin bad++; $display("FAIL cfg_fields: got %h want %h", {rw, temp_reg_d1, temp_output_d2}, {1'b0, 8'h01, CFG_DATA}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfg_busy: got %0b want 1", busy); end
    run_attempt(30, 8'($urandom), 1'b0);
    total++; if ({temp_valid, fault, retry_cnt} !== 4'b0000) begin bad++; $display("FAIL cfg_done_flags: got %b want 0000", {temp_valid, fault, retry_cnt}); end
    wait_start(40, n);
    total++; if (n !== POLL_DIV) begin bad++; $display("FAIL first_read_gap: got %0d want %0d", n + 1, POLL_DIV + 1); end
    total++; if ({rw, temp_reg_d1, temp_output_d2} !== {1'b1, 8'h00, 8'h00}) begin bad++; $display("FAIL rd_fields: got %h want 10000", {rw, temp_reg_d1, temp_output_d2}); end
  endtask

  task automatic test_read_data();
    int n, lat;
    logic [7:0] data;
    for (int k = 0; k < 6; k++) begin
      lat = (k == 0) ? 30 : (k == 1) ? 1 : (k == 2) ? TIMEOUT : int'($urandom_range(2, TIMEOUT - 1));
      data = (k == 0) ? 8'h19 : 8'($urandom);
      temp_error = 4'($urandom);
      run_attempt(lat, data, 1'b0);
      exp_value = data;
      total++; if (temp_valid !== 1'b1) begin bad++; $display("FAIL rd%0d_valid: got %0b want 1", k, temp_valid); end
      total++; if (temp_value !== exp_value) begin bad++; $display("FAIL rd%0d_value: got %h want %h", k, temp_value, exp_value); end
      total++; if ({rw, temp_reg_d1, fault} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL rd%0d_hold: got %h want 100", k, {rw, temp_reg_d1, fault}); end
      tick();
      total++; if (temp_valid !== 1'b0) begin bad++; $display("FAIL rd%0d_valid_pulse: got %0b want 0", k, temp_valid); end
      wait_start(40, n);
      total++; if (n !== POLL_DIV - 1) begin bad++; $display("FAIL rd%0d_gap: got %0d want %0d", k, n + 2, POLL_DIV + 1); end
    end
  endtask

  task automatic test_retry();
    int n, nfails;
    bit failed;
    logic [7:0] data;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        temp_error = 4'd3;
        nfails = MAX_RETRY;
      end else begin
        nfails = int'($urandom_range(0, MAX_RETRY));
      end
      for (int k = 0; k <= nfails; k++) begin
        failed = (k < nfails);
        data = 8'($urandom);
        run_attempt(int'($urandom_range(1, TIMEOUT)), data, failed);
        total++; if (retry_cnt !== exp_retry(k, failed)) begin bad++; $display("FAIL retry%0d_%0d_cnt: got %0d want %0d", r, k, retry_cnt, exp_retry(k, failed)); end
        if (failed) begin
          total++; if ({start, rw, temp_valid} !== 3'b110) begin bad++; $display("FAIL retry%0d_%0d_restart: got %b want 110", r, k, {start, rw, temp_valid}); end
        end else begin
          exp_value = data;
          total++; if ({temp_valid, fault, temp_value} !== {1'b1, 1'b0, exp_value}) begin bad++; $display("FAIL retry%0d_done: got %h want %h", r, {temp_valid, fault, temp_value}, {1'b1, 1'b0, exp_value}); end
        end
      end
      tick();
      wait_start(40, n);
      total++; if (n !== POLL_DIV - 1) begin bad++; $display("FAIL retry%0d_gap: got %0d want %0d", r, n + 2, POLL_DIV + 1); end
    end
  endtask

  task automatic test_err_fault();
    int n;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      run_attempt(int'($urandom_range(1, TIMEOUT)), 8'($urandom), 1'b1);
      if (k < MAX_RETRY) begin
        total++; if ({start, retry_cnt} !== {1'b1, exp_retry(k, 1'b1)}) begin bad++; $display("FAIL errf_%0d_retry: got %b want %b", k, {start, retry_cnt}, {1'b1, exp_retry(k, 1'b1)}); end
      end else begin
        total++; if ({fault, busy, start, temp_valid} !== 4'b1000) begin bad++; $display("FAIL errf_fault: got %b want 1000", {fault, busy, start, temp_valid}); end
        total++; if (temp_value !== exp_value) begin bad++; $display("FAIL errf_value_kept: got %h want %h", temp_value, exp_value); end
      end
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (start === 1'b1) n++;
    end
    total++; if ({n, fault} !== {32'd0, 1'b1}) begin bad++; $display("FAIL errf_parked: got starts=%0d fault=%0b want 0/1", n, fault); end
    enable = 1'b0;
    tick();
    total++; if ({fault, retry_cnt, busy} !== 4'b0000) begin bad++; $display("FAIL errf_cleared: got %b want 0000", {fault, retry_cnt, busy}); end
    enable = 1'b1;
    wait_start(5, n);
    total++; if ({n, rw, temp_reg_d1, temp_output_d2} !== {32'd1, 1'b0, 8'h01, CFG_DATA}) begin bad++; $display("FAIL errf_recfg: got n=%0d %h", n, {rw, temp_reg_d1, temp_output_d2}); end
    run_attempt(int'($urandom_range(1, TIMEOUT)), 8'($urandom), 1'b0);
    wait_start(40, n);
    total++; if (n !== POLL_DIV) begin bad++; $display("FAIL errf_read_gap: got %0d want %0d", n + 1, POLL_DIV + 1); end
  endtask

  task automatic test_timeout();
    int n;
    repeat (TIMEOUT) tick();
    total++; if ({fault, busy} !== 2'b01) begin bad++; $display("FAIL tmo_early: got %b want 01", {fault, busy}); end
    tick();
    total++; if ({fault, busy, start} !== 3'b100) begin bad++; $display("FAIL tmo_fault: got %b want 100", {fault, busy, start}); end
    i2c_end = 1'b1;
    temp_input = ~exp_value;
    tick();
    i2c_end = 1'b0;
    total++; if ({temp_valid, fault, temp_value} !== {1'b0, 1'b1, exp_value}) begin bad++; $display("FAIL tmo_late_end: got %h want %h", {temp_valid, fault, temp_value}, {1'b0, 1'b1, exp_value}); end
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (start === 1'b1) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL tmo_no_start: got %0d want 0", n); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_start(5, n);
    run_attempt(int'($urandom_range(1, TIMEOUT)), 8'($urandom), 1'b0);
    wait_start(40, n);
    total++; if ({n, rw} !== {32'(POLL_DIV), 1'b1}) begin bad++; $display("FAIL rst_setup: got n=%0d rw=%0b", n, rw); end
    repeat (5) tick();
    #2 RES = 1'b1;
    #1;
    exp_value = 8'h00;
    total++; if ({start, rw, temp_reg_d1, temp_output_d2, temp_value, temp_valid, busy, fault, retry_cnt} !== 31'd0) begin bad++; $display("FAIL rst_async: got %h want 0", {start, rw, temp_reg_d1, temp_output_d2, temp_value, temp_valid, busy, fault, retry_cnt}); end
    enable = 1'b0;
    repeat (3) tick();
    RES = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start === 1'b1) n++;
    end
    total++; if ({n, busy, temp_value} !== {32'd0, 1'b0, exp_value}) begin bad++; $display("FAIL rst_quiet: got starts=%0d busy=%0b value=%h", n, busy, temp_value); end
    enable = 1'b1;
    wait_start(5, n);
    total++; if ({n, rw, temp_reg_d1} !== {32'd1, 1'b0, 8'h01}) begin bad++; $display("FAIL rst_recfg: got n=%0d rw=%0b reg=%h", n, rw, temp_reg_d1); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_read_data();
    test_retry();
    test_err_fault();
    test_timeout();
    test_reset_mid_read();
    tick();
    total++; if (b2b_seen !== 1'b0) begin bad++; $display("FAIL start_back_to_back: got %0b want 0", b2b_seen); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
